// File: rtl/oled_pixel_streamer_if.sv
// Byte stream toward the SPI shifter plus the framebuffer read port, as seen
// from the streamer (master) and from the downstream/memory side (slave).
interface oled_pixel_streamer_if;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_data;
    logic        out_dc;
    logic        pix_rd;
    logic [6:0]  pix_x;
    logic [5:0]  pix_y;
    logic [15:0] pix_data;

    modport master (
        output out_valid, out_data, out_dc, pix_rd, pix_x, pix_y,
        input  out_ready, pix_data
    );

    modport slave (
        input  out_valid, out_data, out_dc, pix_rd, pix_x, pix_y,
        output out_ready, pix_data
    );
endinterface

// File: rtl/oled_pixel_streamer.sv
// Emits the OLED window-setup command bytes, then every RGB565 pixel of a
// WIDTH x HEIGHT raster as two data bytes (high first) on a valid/ready stream.
module oled_pixel_streamer #(
    parameter int WIDTH       = 96,
    parameter int HEIGHT      = 64,
    parameter bit AUTO_REPEAT = 1'b0
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  start,
    output logic                  busy,
    output logic                  frame_done,
    oled_pixel_streamer_if.master bus
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_FETCH,
        S_WAIT,
        S_HI,
        S_LO,
        S_DONE
    } state_t;

    localparam logic [6:0]  X_LAST  = 7'(WIDTH - 1);
    localparam logic [5:0]  Y_LAST  = 6'(HEIGHT - 1);
    localparam logic [2:0]  CMD_END = 3'd5;
    // Column range then row range, each: opcode, first, last.
    localparam logic [47:0] CMD_SEQ = {8'h15, 8'h00, 8'(WIDTH - 1),
                                       8'h75, 8'h00, 8'(HEIGHT - 1)};

    logic [7:0] cmd_rom [6];

    for (genvar gi = 0; gi < 6; gi++) begin : g_cmd_rom
        assign cmd_rom[gi] = CMD_SEQ[47 - 8 * gi -: 8];
    end

    state_t     state_reg;
    logic       busy_reg;
    logic       frame_done_reg;
    logic       pix_rd_reg;
    logic       out_valid_reg;
    logic       out_dc_reg;
    logic [7:0] out_data_reg;
    logic [6:0] pix_x_reg;
    logic [5:0] pix_y_reg;
    logic [2:0] cmd_idx_reg;
    logic [7:0] pixel_lo_reg;
    logic       xfer;

    assign xfer = out_valid_reg && bus.out_ready;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_reg      <= S_IDLE;
            busy_reg       <= 1'b0;
            frame_done_reg <= 1'b0;
            pix_rd_reg     <= 1'b0;
            out_valid_reg  <= 1'b0;
            out_dc_reg     <= 1'b0;
            out_data_reg   <= 8'h00;
            pix_x_reg      <= 7'd0;
            pix_y_reg      <= 6'd0;
            cmd_idx_reg    <= 3'd0;
            pixel_lo_reg   <= 8'h00;
        end else begin
            frame_done_reg <= 1'b0;
            pix_rd_reg     <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg     <= S_CMD;
                        busy_reg      <= 1'b1;
                        out_valid_reg <= 1'b1;
                        out_dc_reg    <= 1'b0;
                        out_data_reg  <= cmd_rom[0];
                        cmd_idx_reg   <= 3'd0;
                    end
                end
                S_CMD: begin
                    if (xfer) begin
                        if (cmd_idx_reg == CMD_END) begin
                            state_reg     <= S_FETCH;
                            out_valid_reg <= 1'b0;
                            pix_rd_reg    <= 1'b1;
                            pix_x_reg     <= 7'd0;
                            pix_y_reg     <= 6'd0;
                        end else begin
                            cmd_idx_reg  <= cmd_idx_reg + 3'd1;
                            out_data_reg <= cmd_rom[cmd_idx_reg + 3'd1];
                        end
                    end
                end
                S_FETCH: begin
                    state_reg <= S_WAIT;
                end
                S_WAIT: begin
                    // Read data is valid exactly one cycle after the strobe.
                    state_reg     <= S_HI;
                    out_valid_reg <= 1'b1;
                    out_dc_reg    <= 1'b1;
                    out_data_reg  <= bus.pix_data[15:8];
                    pixel_lo_reg  <= bus.pix_data[7:0];
                end
                S_HI: begin
                    if (xfer) begin
                        state_reg    <= S_LO;
                        out_data_reg <= pixel_lo_reg;
                    end
                end
                S_LO: begin
                    if (xfer) begin
                        out_valid_reg <= 1'b0;
                        if (pix_x_reg < X_LAST) begin
                            pix_x_reg  <= pix_x_reg + 7'd1;
                            pix_rd_reg <= 1'b1;
                            state_reg  <= S_FETCH;
                        end else if (pix_y_reg < Y_LAST) begin
                            pix_x_reg  <= 7'd0;
                            pix_y_reg  <= pix_y_reg + 6'd1;
                            pix_rd_reg <= 1'b1;
                            state_reg  <= S_FETCH;
                        end else begin
                            frame_done_reg <= 1'b1;
                            state_reg      <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (AUTO_REPEAT) begin
                        state_reg     <= S_CMD;
                        out_valid_reg <= 1'b1;
                        out_dc_reg    <= 1'b0;
                        out_data_reg  <= cmd_rom[0];
                        cmd_idx_reg   <= 3'd0;
                    end else begin
                        state_reg <= S_IDLE;
                        busy_reg  <= 1'b0;
                    end
                end
                default: begin
                    state_reg     <= S_IDLE;
                    busy_reg      <= 1'b0;
                    out_valid_reg <= 1'b0;
                end
            endcase
        end
    end

    assign busy          = busy_reg;
    assign frame_done    = frame_done_reg;
    assign bus.pix_rd    = pix_rd_reg;
    assign bus.pix_x     = pix_x_reg;
    assign bus.pix_y     = pix_y_reg;
    assign bus.out_valid = out_valid_reg;
    assign bus.out_data  = out_data_reg;
    assign bus.out_dc    = out_dc_reg;

endmodule

// File: tb/tb_oled_pixel_streamer.sv
// Three streamers (96x64, 4x2, 2x2 auto-repeat) checked against a raster
// model of the byte stream and framebuffer addresses, plus directed scenarios.
module tb_oled_pixel_streamer;

    logic       clk = 1'b0;
    logic [2:0] resetn = 3'b111;
    logic [2:0] start = 3'b000;
    logic [2:0] ready = 3'b111;
    logic [15:0] pdata [3];

    wire [2:0] busy_w, done_w, ov, odc, prd;
    wire [7:0] od [3];
    wire [6:0] px [3];
    wire [5:0] py [3];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        oled_pixel_streamer_if bus ();

        oled_pixel_streamer #(
            .WIDTH      (gi == 0 ? 96 : (gi == 1 ? 4 : 2)),
            .HEIGHT     (gi == 0 ? 64 : 2),
            .AUTO_REPEAT(gi == 2)
        ) u_dut (
            .clk       (clk),
            .resetn    (resetn[gi]),
            .start     (start[gi]),
            .busy      (busy_w[gi]),
            .frame_done(done_w[gi]),
            .bus       (bus)
        );

        assign bus.out_ready = ready[gi];
        assign bus.pix_data  = pdata[gi];
        assign ov[gi]  = bus.out_valid;
        assign odc[gi] = bus.out_dc;
        assign od[gi]  = bus.out_data;
        assign prd[gi] = bus.pix_rd;
        assign px[gi]  = bus.pix_x;
        assign py[gi]  = bus.pix_y;
    end

    int n_pass = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_total++;
        if (act === exp_v) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
    endtask

    function automatic int w_of(input int d);
        return (d == 0) ? 96 : ((d == 1) ? 4 : 2);
    endfunction

    function automatic int h_of(input int d);
        return (d == 0) ? 64 : 2;
    endfunction

    function automatic logic [15:0] pix_val(input logic [6:0] x, input logic [5:0] y);
        return {y[4:0], x, 4'h0};
    endfunction

    // Expected {dc, byte} at position idx of one frame's byte stream.
    function automatic logic [8:0] exp_byte(input int d, input int idx);
        int w, h, k;
        logic [15:0] p;
        w = w_of(d);
        h = h_of(d);
        case (idx)
            0: return 9'h015;
            1: return 9'h000;
            2: return {1'b0, 8'(w - 1)};
            3: return 9'h075;
            4: return 9'h000;
            5: return {1'b0, 8'(h - 1)};
            default: ;
        endcase
        k = (idx - 6) / 2;
        if (k >= w * h) return 9'h0EE;
        p = pix_val(7'(k % w), 6'(k / w));
        return ((idx - 6) % 2 == 0) ? {1'b1, p[15:8]} : {1'b1, p[7:0]};
    endfunction

    int         byte_idx [3];
    int         pix_cnt [3];
    int         frames [3];
    logic       hold_q [3];
    logic [8:0] hold_byte [3];
    logic [7:0] cap [3][32];
    logic [7:0] snap_hi, snap_lo;
    logic       rd_q [3];
    logic [6:0] xq [3];
    logic [5:0] yq [3];

    initial begin
        for (int d = 0; d < 3; d++) begin
            byte_idx[d] = 0;
            pix_cnt[d]  = 0;
            frames[d]   = 0;
            hold_q[d]   = 1'b0;
            hold_byte[d] = 9'h0;
            rd_q[d]     = 1'b0;
            xq[d]       = 7'd0;
            yq[d]       = 6'd0;
            pdata[d]    = 16'h0;
        end
        snap_hi = 8'h00;
        snap_lo = 8'h00;
    end

    // Framebuffer model: answers a read one cycle later, junk otherwise.
    always @(posedge clk) begin
        #1;
        for (int d = 0; d < 3; d++)
            pdata[d] = rd_q[d] ? pix_val(xq[d], yq[d]) : 16'($urandom);
    end

    // Single compare process: every cycle, every DUT.
    always @(negedge clk) begin
        for (int d = 0; d < 3; d++) begin
            int w, h;
            w = w_of(d);
            h = h_of(d);
            rd_q[d] = prd[d];
            xq[d]   = px[d];
            yq[d]   = py[d];
            if (!resetn[d]) begin
                chk("rst_valid", {31'd0, ov[d]}, 0);
                chk("rst_busy", {31'd0, busy_w[d]}, 0);
                chk("rst_done", {31'd0, done_w[d]}, 0);
                chk("rst_rd", {31'd0, prd[d]}, 0);
                byte_idx[d] = 0;
                pix_cnt[d]  = 0;
                hold_q[d]   = 1'b0;
            end else begin
                if (hold_q[d])
                    chk("hold_stable", {ov[d], odc[d], od[d]}, {1'b1, hold_byte[d]});
                if (ov[d] && ready[d]) begin
                    chk("byte", {odc[d], od[d]}, exp_byte(d, byte_idx[d]));
                    if (byte_idx[d] < 32) cap[d][byte_idx[d]] = od[d];
                    if (d == 0 && byte_idx[d] == 200) snap_hi = od[d];
                    if (d == 0 && byte_idx[d] == 201) snap_lo = od[d];
                    byte_idx[d]++;
                end
                if (prd[d]) begin
                    chk("pix_addr", {py[d], px[d]}, {6'(pix_cnt[d] / w), 7'(pix_cnt[d] % w)});
                    pix_cnt[d]++;
                end
                if (done_w[d]) begin
                    chk("done_bytes", byte_idx[d], 6 + 2 * w * h);
                    chk("done_pix", pix_cnt[d], w * h);
                    byte_idx[d] = 0;
                    pix_cnt[d]  = 0;
                    frames[d]++;
                end
                if (ov[d] || prd[d] || done_w[d])
                    chk("busy_active", {31'd0, busy_w[d]}, 1);
                hold_q[d]    = ov[d] && !ready[d];
                hold_byte[d] = {odc[d], od[d]};
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_frame(input int d);
        start[d] = 1'b1;
        step();
        start[d] = 1'b0;
        chk("first_byte", {ov[d], odc[d], od[d]}, {1'b1, 1'b0, 8'h15});
    endtask

    // Counts cycles from the current (first CMD) cycle through frame_done.
    task automatic run_frame(input int d, input bit rnd, input int max, output int n);
        n = 1;
        while (!done_w[d] && n < max) begin
            if (rnd) ready[d] = 1'($urandom_range(0, 1));
            step();
            n++;
        end
        ready[d] = 1'b1;
    endtask

    logic [7:0] saved [32];
    int n, k, f0, extra;
    bit found;
    logic [7:0] cmd0 [6];
    logic [7:0] cmd1 [6];

    initial begin
        cmd0 = '{8'h15, 8'h00, 8'h5F, 8'h75, 8'h00, 8'h3F};
        cmd1 = '{8'h15, 8'h00, 8'h03, 8'h75, 8'h00, 8'h01};
        #1 resetn = 3'b000;
        repeat (3) step();
        for (int d = 0; d < 3; d++) begin
            chk("rst_xy", {py[d], px[d]}, 0);
            chk("rst_data_dc", {odc[d], od[d]}, 0);
        end
        resetn = 3'b111;
        step();

        // Default raster, ready held high.
        start_frame(0);
        run_frame(0, 1'b0, 30000, n);
        chk("t1_frame_len", n, 24583);
        for (int i = 0; i < 6; i++) chk("t1_cmd", cap[0][i], cmd0[i]);
        chk("t1_pix97_hi", snap_hi, 8'h08);
        chk("t1_pix97_lo", snap_lo, 8'h10);
        step();
        chk("t1_idle_busy", {31'd0, busy_w[0]}, 0);
        $display("t1 default frame: %0d cycles, frames=%0d", n, frames[0]);

        // 4x2 raster, ready held high.
        start_frame(1);
        run_frame(1, 1'b0, 200, n);
        chk("t2_frame_len", n, 39);
        for (int i = 0; i < 6; i++) chk("t2_cmd", cap[1][i], cmd1[i]);
        chk("t2_pix5_hi", cap[1][16], 8'h08);
        chk("t2_pix5_lo", cap[1][17], 8'h10);
        for (int i = 0; i < 22; i++) saved[i] = cap[1][i];
        step();
        $display("t2 4x2 frame: %0d cycles", n);

        // Same raster under random backpressure.
        for (int i = 0; i < 22; i++) cap[1][i] = 8'hAA;
        start_frame(1);
        run_frame(1, 1'b1, 2000, n);
        chk("t3_done", {31'd0, done_w[1]}, 1);
        for (int i = 0; i < 22; i++) chk("t3_same_bytes", cap[1][i], saved[i]);
        step();
        $display("t3 4x2 frame with backpressure: %0d cycles", n);

        // start pulsed during HI of pixel 10 must be ignored.
        f0 = frames[0];
        start_frame(0);
        k = 0;
        found = 1'b0;
        while (!found && k < 500) begin
            found = ov[0] && odc[0] && px[0] == 7'd10 && py[0] == 6'd0;
            if (!found) begin
                step();
                k++;
            end
        end
        chk("t4_hi_seen", {31'd0, found}, 1);
        start[0] = 1'b1;
        step();
        start[0] = 1'b0;
        run_frame(0, 1'b0, 30000, n);
        chk("t4_done", {31'd0, done_w[0]}, 1);
        chk("t4_busy_at_done", {31'd0, busy_w[0]}, 1);
        step();
        chk("t4_busy_fall", {31'd0, busy_w[0]}, 0);
        extra = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (ov[0] || busy_w[0]) extra++;
        end
        chk("t4_no_restart", extra, 0);
        chk("t4_one_frame", frames[0] - f0, 1);
        $display("t4 start ignored mid-frame: frames=%0d", frames[0] - f0);

        // Reset during the LO byte of pixel 20 while stalled.
        f0 = frames[0];
        start_frame(0);
        k = 0;
        while (!(prd[0] && px[0] == 7'd20) && k < 200) begin
            step();
            k++;
        end
        step();
        step();
        step();
        ready[0] = 1'b0;
        step();
        chk("t5_lo_byte", {ov[0], odc[0], od[0]}, {1'b1, 1'b1, 8'h40});
        resetn[0] = 1'b0;
        #1;
        chk("t5_rst_valid", {31'd0, ov[0]}, 0);
        chk("t5_rst_busy", {31'd0, busy_w[0]}, 0);
        chk("t5_rst_data", {odc[0], od[0]}, 0);
        repeat (2) step();
        ready[0] = 1'b1;
        resetn[0] = 1'b1;
        step();
        chk("t5_no_done", frames[0] - f0, 0);
        start_frame(0);
        repeat (20) step();
        resetn[0] = 1'b0;
        step();
        resetn[0] = 1'b1;
        step();
        $display("t5 reset mid-byte and replay");

        // Auto repeat: three back-to-back identical frames.
        start_frame(2);
        for (int f = 0; f < 3; f++) begin
            run_frame(2, 1'b0, 100, n);
            chk("t6_frame_len", n, 23);
            if (f == 0) for (int i = 0; i < 14; i++) saved[i] = cap[2][i];
            else for (int i = 0; i < 14; i++) chk("t6_same_frame", cap[2][i], saved[i]);
            step();
            chk("t6_auto_restart", {busy_w[2], ov[2], odc[2], od[2]}, {1'b1, 1'b1, 1'b0, 8'h15});
            $display("t6 auto frame %0d: %0d cycles", f, n);
        end
        resetn[2] = 1'b0;
        step();
        resetn[2] = 1'b1;
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
